ins_dec_pipe: RTL
=================

// Module: ins_dec_pipe
// PURPOSE
//  Registered, parametrised successor to the combinational decoder. Sits between IMEM fetch and
//  RF/ALU issue. Decodes instruction fields for any register-file size, uses valid/ready
//  handshakes on both sides, keeps a per-register pending-write scoreboard, stalls on RAW
//  hazards, and counts illegal instructions.
// PARAMETERS
//  INSTR_W   16  instruction width; opcode always [3:0]
//  RA_W      3   register address width; NUM_REGS = 2**RA_W
//  IMM_W     INSTR_W-4-2*RA_W (derived, localparam)  unextended immediate width; must be >= RA_W
//  CNT_W     8   illegal-instruction counter width
// PORTS
//  clk_i          in   1        clock, rising edge
//  arst_ni        in   1        asynchronous active-low reset
//  imem_rdata_i   in   INSTR_W  fetched instruction
//  imem_valid_i   in   1        imem_rdata_i valid
//  imem_ready_o   out  1        decoder accepts imem_rdata_i this cycle
//  dec_valid_o    out  1        decoded bundle valid
//  dec_ready_i    in   1        downstream accepts bundle
//  func_o         out  func_t   opcode (simple_processor_pkg enum)
//  we_o           out  1        RF write enable for this instruction
//  rd_addr_o      out  RA_W     dest = instr[INSTR_W-1 -: RA_W]
//  rs1_addr_o     out  RA_W     src1 = instr[INSTR_W-1-RA_W -: RA_W]
//  rs2_addr_o     out  RA_W     src2 = instr[IMM_W+3 -: RA_W] (top bits of imm field)
//  imm_o          out  IMM_W    imm = instr[IMM_W+3:4]
//  illegal_o      out  1        bundle is illegal (PC must reload boot address)
//  wb_valid_i     in   1        writeback completing this cycle
//  wb_addr_i      in   RA_W     writeback register
//  flush_i        in   1        discard held bundle, block acceptance this cycle
//  illegal_cnt_o  out  CNT_W    saturating count of accepted illegal instructions
// BEHAVIOUR
//  Decode (comb, on imem_rdata_i): legal opcodes ADDI ADD SUB AND OR XOR NOT LOAD STORE SLL SLR
//   SLLI SLRI. illegal = !legal_opcode || rd==0. we = !illegal && func!=STORE.
//   uses_rs2 = func in {ADD,SUB,AND,OR,XOR,SLL,SLR,STORE}; every legal op uses rs1.
//   Illegal instructions check no hazards.
//  Hazard: src pending = pending[rs] || (dec_valid_o && we_o && rd_addr_o==rs).
//   hazard = !illegal && (src1 pending || (uses_rs2 && src2 pending)).
//  imem_ready_o = !flush_i && !hazard && (!dec_valid_o || dec_ready_i). Ready may depend on rdata.
//  Accept = imem_valid_i && imem_ready_o. On accept, the output register loads all fields and
//   dec_valid_o=1 next cycle (latency 1). Full throughput when no hazard and dec_ready_i=1.
//  Output fire = dec_valid_o && dec_ready_i. After a fire with no accept: dec_valid_o=0.
//   Outputs stay stable while dec_valid_o && !dec_ready_i.
//  Scoreboard pending[NUM_REGS]: on fire with we_o, set pending[rd_addr_o]. On wb_valid_i, clear
//   pending[wb_addr_i]. Same bit set and cleared in one cycle -> set wins. pending[0] is always 0.
//  flush_i: next cycle dec_valid_o=0. No accept, no fire credit (held bundle's rd is NOT set).
//   Scoreboard is not cleared; in-flight writebacks still retire.
//  illegal_cnt_o: +1 per accepted illegal instruction; saturates at all-ones.
//  Reset (async, arst_ni=0): dec_valid_o=0, all output fields 0, illegal_o=0, pending=0,
//   illegal_cnt_o=0. imem_ready_o is then comb-driven. Reset mid-stall drops the held bundle.
//  No FSM beyond the valid bit; the 1-entry pipeline register is the only buffering.
// TESTING
//  1. Reset, then ADDI rd=1 rs1=2 imm=5, dec_ready=1 -> next cycle dec_valid=1, we=1, rd=1, imm=5.
//  2. ADD r3=r1+r2 right after ADDI r1 (not yet wb) -> imem_ready=0 until wb_valid_i, wb_addr=1;
//     accepted the same cycle as wb.
//  3. Opcode 4'hF, then ADD with rd=0 -> illegal_o=1, we=0 for both; illegal_cnt_o=2; with
//     CNT_W=2, 5 illegals -> cnt=3.
//  4. dec_ready_i=0 for 3 cycles with a bundle held -> outputs stable, imem_ready=0; release -> fire.
//  5. Same-cycle fire of ADDI r4 and wb r4 -> pending[4]=1 afterwards.
//  6. flush_i with bundle held and imem_valid=1 -> dec_valid=0 next, no accept, pending unchanged;
//     arst_ni low mid-stall -> all cleared.

Source files
------------

// File: rtl/ins_dec_pipe.sv
// Registered instruction decoder between IMEM fetch and RF/ALU issue.
// One-entry output register with valid/ready on both sides, a per-register
// pending-write scoreboard for RAW stalls, and a saturating illegal counter.

package simple_processor_pkg;
   typedef enum logic [3:0] {
      ADD   = 4'h0,
      ADDI  = 4'h1,
      SUB   = 4'h2,
      AND   = 4'h3,
      OR    = 4'h4,
      XOR   = 4'h5,
      NOT   = 4'h6,
      LOAD  = 4'h7,
      STORE = 4'h8,
      SLL   = 4'h9,
      SLR   = 4'hA,
      SLLI  = 4'hB,
      SLRI  = 4'hC
   } func_t;
endpackage

module ins_dec_pipe
   import simple_processor_pkg::*;
#(
   parameter  int INSTR_W  = 16,
   parameter  int RA_W     = 3,
   parameter  int CNT_W    = 8,
   // immediate field sits between rs1 and the opcode; must be >= RA_W so rs2 fits
   localparam int IMM_W    = INSTR_W - 4 - 2*RA_W,
   localparam int NUM_REGS = 2**RA_W
) (
   input  logic               clk_i,
   input  logic               arst_ni,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   input  logic               imem_valid_i,
   output logic               imem_ready_o,
   output logic               dec_valid_o,
   input  logic               dec_ready_i,
   output func_t              func_o,
   output logic               we_o,
   output logic [RA_W-1:0]    rd_addr_o,
   output logic [RA_W-1:0]    rs1_addr_o,
   output logic [RA_W-1:0]    rs2_addr_o,
   output logic [IMM_W-1:0]   imm_o,
   output logic               illegal_o,
   input  logic               wb_valid_i,
   input  logic [RA_W-1:0]    wb_addr_i,
   input  logic               flush_i,
   output logic [CNT_W-1:0]   illegal_cnt_o
);

   // field extraction from the fetched word
   logic [3:0]       w_op;
   logic [RA_W-1:0]  w_rd, w_rs1, w_rs2;
   logic [IMM_W-1:0] w_imm;
   logic             w_legal_op, w_uses_rs2, w_illegal, w_we;

   assign w_op  = imem_rdata_i[3:0];
   assign w_rd  = imem_rdata_i[INSTR_W-1 -: RA_W];
   assign w_rs1 = imem_rdata_i[INSTR_W-1-RA_W -: RA_W];
   assign w_rs2 = imem_rdata_i[IMM_W+3 -: RA_W];
   assign w_imm = imem_rdata_i[IMM_W+3:4];

   // output register state
   logic                r_vld, r_we, r_ill;
   func_t               r_func;
   logic [RA_W-1:0]     r_rd, r_rs1, r_rs2;
   logic [IMM_W-1:0]    r_imm;
   logic [NUM_REGS-1:0] r_pend, w_pend_nxt;
   logic [CNT_W-1:0]    r_cnt;

   logic w_s1_pend, w_s2_pend, w_hazard, w_accept, w_fire;

   // opcode legality and which sources the instruction reads
   always_comb begin
      w_legal_op = 1'b1;
      w_uses_rs2 = 1'b0;
      case (func_t'(w_op))
         ADD, SUB, AND, OR, XOR, SLL, SLR, STORE: w_uses_rs2 = 1'b1;
         ADDI, NOT, LOAD, SLLI, SLRI:             w_uses_rs2 = 1'b0;
         default:                                 w_legal_op = 1'b0;
      endcase
   end

   assign w_illegal = !w_legal_op || (w_rd == '0);
   assign w_we      = !w_illegal && (func_t'(w_op) != STORE);

   // A source is busy if an older instruction still owes it a write: either
   // already issued (scoreboard) or sitting in the output register. A
   // writeback retiring this cycle frees the register immediately.
   always_comb begin
      w_s1_pend = (r_pend[w_rs1] && !(wb_valid_i && wb_addr_i == w_rs1))
                  || (r_vld && r_we && r_rd == w_rs1);
      w_s2_pend = (r_pend[w_rs2] && !(wb_valid_i && wb_addr_i == w_rs2))
                  || (r_vld && r_we && r_rd == w_rs2);
   end

   assign w_hazard     = !w_illegal && (w_s1_pend || (w_uses_rs2 && w_s2_pend));
   assign imem_ready_o = !flush_i && !w_hazard && (!r_vld || dec_ready_i);
   assign w_accept     = imem_valid_i && imem_ready_o;
   // a flushed bundle is dropped, so it earns no scoreboard entry
   assign w_fire       = r_vld && dec_ready_i && !flush_i;

   // scoreboard next state: clear on writeback, set on issue (set wins), r0 never pending
   always_comb begin
      w_pend_nxt = r_pend;
      if (wb_valid_i)     w_pend_nxt[wb_addr_i] = 1'b0;
      if (w_fire && r_we) w_pend_nxt[r_rd]      = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   // valid bit: flush kills, accept fills, fire drains
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni)      r_vld <= 1'b0;
      else if (flush_i)  r_vld <= 1'b0;
      else if (w_accept) r_vld <= 1'b1;
      else if (w_fire)   r_vld <= 1'b0;
   end

   // bundle fields load only on accept, so they hold while stalled downstream
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_func <= func_t'(4'h0);
         r_we   <= 1'b0;
         r_ill  <= 1'b0;
         r_rd   <= '0;
         r_rs1  <= '0;
         r_rs2  <= '0;
         r_imm  <= '0;
      end else if (w_accept) begin
         r_func <= func_t'(w_op);
         r_we   <= w_we;
         r_ill  <= w_illegal;
         r_rd   <= w_rd;
         r_rs1  <= w_rs1;
         r_rs2  <= w_rs2;
         r_imm  <= w_imm;
      end
   end

   // pending-write scoreboard register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) r_pend <= '0;
      else          r_pend <= w_pend_nxt;
   end

   // saturating count of accepted illegal instructions
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni)                                    r_cnt <= '0;
      else if (w_accept && w_illegal && r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
   end

   assign dec_valid_o   = r_vld;
   assign func_o        = r_func;
   assign we_o          = r_we;
   assign illegal_o     = r_ill;
   assign rd_addr_o     = r_rd;
   assign rs1_addr_o    = r_rs1;
   assign rs2_addr_o    = r_rs2;
   assign imm_o         = r_imm;
   assign illegal_cnt_o = r_cnt;

endmodule
